// File: rtl/gpio_in_debounce.sv
// +----------------------------------------------------------------------------+
// | gpio_in_debounce: synchronises and debounces raw switch/button inputs, and  |
// | provides rise/fall strobes plus sticky write-1-to-clear event flags.        |
// | Optional interrupt output: define GPIO_DEBOUNCE_IRQ_EN.                     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module gpio_in_debounce #(
  parameter int unsigned      WIDTH           = 12,
  parameter int unsigned      SYNC_STAGES     = 2,
  parameter int unsigned      CNT_WIDTH       = 20,
  parameter int unsigned      DEBOUNCE_CYCLES = 500000,
  parameter logic [WIDTH-1:0] RST_VAL         = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] stable_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic [WIDTH-1:0] evt_o,
`ifdef GPIO_DEBOUNCE_IRQ_EN
  input  logic [WIDTH-1:0] irq_mask_i,
  output logic             irq_o,
`endif
  input  logic [WIDTH-1:0] evt_clr_i
);

  localparam logic [CNT_WIDTH-1:0] CNT_TERM = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_s;
  logic [WIDTH-1:0] accept;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] evt_q, evt_d;

  // Only stage 0 samples the asynchronous input.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < int'(SYNC_STAGES); k++) begin
        sync_q[k] <= RST_VAL;
      end
    end else begin
      sync_q[0] <= raw_i;
      for (int k = 1; k < int'(SYNC_STAGES); k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  genvar i;
  generate
    for (i = 0; i < int'(WIDTH); i++) begin : g_bit
      logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
      logic                 acc;

      always_comb begin
        cnt_d = cnt_q;
        acc   = 1'b0;
        if (sync_s[i] == stable_q[i]) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_TERM) begin
          cnt_d = '0;
          acc   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign accept[i] = acc;
    end
  endgenerate

  always_comb begin
    stable_d = (stable_q & ~accept) | (sync_s & accept);
    rise_d   = accept & sync_s;
    fall_d   = accept & ~sync_s;
    // Set takes priority over a simultaneous clear.
    evt_d    = (evt_q & ~evt_clr_i) | rise_q | fall_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stable_q <= RST_VAL;
      rise_q   <= '0;
      fall_q   <= '0;
      evt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      evt_q    <= evt_d;
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
  assign evt_o    = evt_q;

`ifdef GPIO_DEBOUNCE_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |(evt_q & irq_mask_i);
    end
  end

  assign irq_o = irq_q;
`endif

`ifndef SYNTHESIS
  initial begin : p_param_check
    assert (DEBOUNCE_CYCLES >= 1 && 64'(DEBOUNCE_CYCLES) < (64'd1 << CNT_WIDTH))
      else $fatal(1, "gpio_in_debounce: DEBOUNCE_CYCLES out of range for CNT_WIDTH");
    assert (SYNC_STAGES >= 2 && SYNC_STAGES <= 4)
      else $fatal(1, "gpio_in_debounce: SYNC_STAGES must be 2..4");
  end
`endif

endmodule

`default_nettype wire

// File: doc/gpio_in_debounce.md
Name: gpio_in_debounce

Overview:
- Input-conditioning stage between raw board switches/buttons and the SoC GPIO input bus.
- Synchronises each asynchronous input bit and debounces it with a per-bit stability counter. Outputs a clean level vector for the gpio input word.
- Also provides one-cycle rise/fall strobes and sticky write-1-to-clear event flags, so polled software does not miss short button presses.
- The reset button itself is not routed through this block.

Parameters:
- WIDTH, 12, number of conditioned input bits (8 switches + 4 buttons).
- SYNC_STAGES, 2, flip-flop synchroniser depth per bit; legal range 2..4.
- CNT_WIDTH, 20, width of each per-bit stability counter.
- DEBOUNCE_CYCLES, 500000, consecutive stable clocks required before a level is accepted (10 ms at 50 MHz); legal range 1..2^CNT_WIDTH-1.
- RST_VAL, 0, WIDTH-bit reset value for the synchroniser chain and stable_o.

Ports:
- clk_i  input  1  system clock
- rst_ni  input  1  asynchronous active-low reset
- raw_i  input  WIDTH  raw asynchronous switch/button levels
- stable_o  output  WIDTH  debounced level, to the gpio input word
- rise_o  output  WIDTH  one-cycle strobe per bit on an accepted 0->1 transition
- fall_o  output  WIDTH  one-cycle strobe per bit on an accepted 1->0 transition
- evt_o  output  WIDTH  sticky per-bit event flag (any accepted transition)
- evt_clr_i  input  WIDTH  write-1-to-clear strobe for evt_o, one bit per flag

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - Asserting rst_ni=0 immediately forces: sync chain=RST_VAL, stable_o=RST_VAL, all counters=0, rise_o=0, fall_o=0, evt_o=0.
  - Deassertion must be synchronous to clk_i at the system level. The block takes no special action on deassertion.
  - Reset mid-debounce discards the count. No strobe is produced for the aborted transition.
- Synchroniser: raw_i passes through SYNC_STAGES flops per bit. s[i] denotes the last stage. The first stage is the only flop sampling the async input.
- Per-bit counter cnt[i]:
  - If s[i]==stable_o[i]: cnt[i] <= 0.
  - Else if cnt[i]==DEBOUNCE_CYCLES-1: stable_o[i] <= s[i] and cnt[i] <= 0; in the same clock edge rise_o[i] <= s[i] and fall_o[i] <= ~s[i].
  - Else: cnt[i] <= cnt[i]+1.
  - Any glitch back to the stable value restarts the count from 0. Counters never wrap: the terminal value is always reached before 2^CNT_WIDTH-1.
- Strobes:
  - rise_o/fall_o are registered and high for exactly one cycle, aligned with the first cycle stable_o shows the new level.
  - They are never both high on the same bit.
- Latency: a clean step on raw_i held indefinitely appears on stable_o after SYNC_STAGES + DEBOUNCE_CYCLES clocks (±1 for async sampling).
  - DEBOUNCE_CYCLES=1 gives SYNC_STAGES+1 clocks.
  - Minimum spacing between accepted transitions on one bit is DEBOUNCE_CYCLES clocks.
- Event flags: evt_o[i] <= (evt_o[i] & ~evt_clr_i[i]) | rise_o[i] | fall_o[i], evaluated on the registered strobes, so the flag sets the cycle after the strobe.
  - Simultaneous set and clear on the same bit: set wins and evt_o[i] stays 1.
  - Clearing an already-clear flag has no effect.
- Bits are fully independent. Simultaneous transitions on several bits produce independent strobes in the same cycle.
- The parameter constraint DEBOUNCE_CYCLES>=1 and < 2^CNT_WIDTH is checked by a simulation-only initial assertion.

Optional Feature:
- Macro GPIO_DEBOUNCE_IRQ_EN.
- When defined, the block adds:
  - port irq_mask_i (input, WIDTH) and port irq_o (output, 1).
  - irq_o is a registered OR-reduction of (evt_o & irq_mask_i). It is 0 in reset and rises one cycle after the qualifying evt_o bit sets.
  - irq_o is a level, not a pulse. It drops one cycle after the last masked flag is cleared or masked.
- When undefined: no irq ports exist and behaviour is otherwise identical.

Test Plan:
- Reset behaviour (bench params WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, RST_VAL=0): with raw_i=4'hF, pulse rst_ni low mid-cycle -> all outputs 0 immediately. Release -> stable_o=4'hF exactly 6 clocks later, with rise_o=4'hF for one cycle and evt_o=4'hF the following cycle.
- Glitch rejection: from stable 0, drive raw_i[0]=1 for 3 clocks then 0 -> stable_o[0] stays 0, no strobe. A subsequent 4+ clock high -> stable_o[0]=1 after 6 clocks, rise_o[0] single pulse.
- Bounce pattern: raw_i[1] toggles 1,0,1,0,1 at 1-clock intervals then holds 1 -> exactly one rise_o[1] pulse, 6 clocks after the final edge. Then hold 0 for 10 clocks -> exactly one fall_o[1].
- Event clear: with evt_o[2]=1, assert evt_clr_i[2] for one cycle -> evt_o[2]=0 next cycle. Assert evt_clr_i[3] in the same cycle rise_o[3] is high -> evt_o[3] ends 1.
- Reset mid-debounce: raw_i[0] high for 2 clocks, then rst_ni low for 1 clock and released while raw_i[0] stays high -> no strobe before reset. stable_o[0]=1 arrives 6 clocks after release, not earlier.
- IRQ (GPIO_DEBOUNCE_IRQ_EN defined): irq_mask_i=4'b0100, accepted rise on bit 2 -> irq_o=1 one cycle after evt_o[2]. A rise on bit 1 alone -> irq_o stays 0. Clearing evt_o[2] -> irq_o=0 one cycle later.
